axis_deadlock_watchdog: RTL and testbench



---
 rtl/deadlock_mon_pkg.sv | 24 ++
 rtl/deadlock_prio_enc.sv | 31 +++
 rtl/axis_deadlock_watchdog.sv | 154 +++++++++++++++
 tb/tb_axis_deadlock_watchdog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// ----------------------------------------------------------------------------
// deadlock_mon_pkg
// Shared types and defaults for the AXI-Stream deadlock watchdog.
//   state_e      : watchdog FSM states (RUN, SUSPECT, DEADLOCK)
//   DEF_CNT_W    : default stall counter width
//   DEF_THRESHOLD: default consecutive-stall threshold
//   idx_w()      : index width for an n-entry vector (minimum 1 bit)
// ----------------------------------------------------------------------------
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } state_e;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_THRESHOLD = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deadlock_prio_enc.sv
// ----------------------------------------------------------------------------
// deadlock_prio_enc
// Lowest-set-bit encoder.
//   vec_i : input vector (N bits)
//   idx_o : index of the lowest set bit, 0 when none set
//   vld_o : 1 when any bit of vec_i is set
// ----------------------------------------------------------------------------
import deadlock_mon_pkg::*;

module deadlock_prio_enc #(
    parameter int N = 2,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    // Scan high to low so the lowest set bit is the last writer.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_deadlock_watchdog.sv
// ----------------------------------------------------------------------------
// axis_deadlock_watchdog
// Classifies an HLS kernel as progressing or stalled each cycle, counts
// consecutive stalled cycles and latches a sticky deadlock flag together with
// a snapshot of which stream ports were blocked at entry.
//
// Ports:
//   kernel_monitor_clock : monitor clock
//   kernel_monitor_reset : asynchronous active-high reset
//   axis_block_sigs      : per stream port, 1 = blocked
//   inst_idle_sigs       : per instance, 1 = idle
//   inst_block_sigs      : per instance, 1 = blocked on internal channel
//   clear                : synchronous release of a latched deadlock
//   kernel_block         : sticky deadlock flag
//   deadlock_pulse       : one-cycle pulse on deadlock entry
//   block_cause          : axis_block_sigs captured at entry
//   first_chan           : lowest set index of block_cause, 0 if none
//   stall_cnt            : current consecutive stalled-cycle count
//
// Optional build macro DEADLOCK_MON_REPORT_EN: prints a report on deadlock
// entry and ends the simulation two cycles after entry unless clear is seen.
// Outputs behave identically with or without it.
// ----------------------------------------------------------------------------
import deadlock_mon_pkg::*;

module axis_deadlock_watchdog #(
    parameter int N_AXIS    = 2,
    parameter int N_INST    = 3,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic                      kernel_monitor_clock,
    input  logic                      kernel_monitor_reset,
    input  logic [N_AXIS-1:0]         axis_block_sigs,
    input  logic [N_INST-1:0]         inst_idle_sigs,
    input  logic [N_INST-1:0]         inst_block_sigs,
    input  logic                      clear,
    output logic                      kernel_block,
    output logic                      deadlock_pulse,
    output logic [N_AXIS-1:0]         block_cause,
    output logic [idx_w(N_AXIS)-1:0]  first_chan,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int               FC_W = idx_w(N_AXIS);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);

    state_e            state_q;
    logic              kb_q;
    logic              pulse_q;
    logic [N_AXIS-1:0] cause_q;
    logic [FC_W-1:0]   fc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              stalled;
    logic [CNT_W-1:0]  cnt_d;
    logic              enter;
    logic [FC_W-1:0]   enc_idx;
    logic              enc_vld;

    // Every instance waiting (idle or blocked), something actually blocked,
    // and not simply a fully idle kernel.
    assign stalled = (&(inst_idle_sigs | inst_block_sigs))
                   & ((|axis_block_sigs) | (|inst_block_sigs))
                   & ~(&inst_idle_sigs);

    // cnt_q is zero in RUN, so the same increment covers the first stalled
    // cycle and the THRESHOLD==1 direct entry.
    assign cnt_d = cnt_q + CNT_W'(1);
    assign enter = stalled && !clear && (state_q != DEADLOCK) && (cnt_d == THR);

    deadlock_prio_enc #(.N(N_AXIS), .W(FC_W)) u_enc (
        .vec_i (axis_block_sigs),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            state_q <= RUN;
            kb_q    <= 1'b0;
            pulse_q <= 1'b0;
            cause_q <= '0;
            fc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (clear) begin
                state_q <= RUN;
                kb_q    <= 1'b0;
                cause_q <= '0;
                fc_q    <= '0;
                cnt_q   <= '0;
            end else if (enter) begin
                state_q <= DEADLOCK;
                kb_q    <= 1'b1;
                pulse_q <= 1'b1;
                cause_q <= axis_block_sigs;
                fc_q    <= enc_vld ? enc_idx : '0;
                cnt_q   <= cnt_d;
            end else begin
                case (state_q)
                    RUN: begin
                        if (stalled) begin
                            state_q <= SUSPECT;
                            cnt_q   <= cnt_d;
                        end
                    end
                    SUSPECT: begin
                        if (stalled) begin
                            cnt_q <= cnt_d;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end
                    end
                    DEADLOCK: ;  // frozen until clear
                    default: begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign kernel_block   = kb_q;
    assign deadlock_pulse = pulse_q;
    assign block_cause    = cause_q;
    assign first_chan     = fc_q;
    assign stall_cnt      = cnt_q;

`ifdef DEADLOCK_MON_REPORT_EN
    logic fin_arm_q;

    // Report the cycle after entry, then stop one cycle later if the
    // deadlock was not released in between.
    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            fin_arm_q <= 1'b0;
        end else if (pulse_q) begin
            $display("[%0t] deadlock: block_cause=%b first_chan=%0d inst_block=%b",
                     $time, cause_q, fc_q, inst_block_sigs);
            fin_arm_q <= !clear;
        end else if (fin_arm_q) begin
            fin_arm_q <= 1'b0;
            if (!clear) $finish;
        end
    end
`else
    // Silent build: the deadlock is observed through kernel_block only.
`endif

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
import deadlock_mon_pkg::*;

module tb_axis_deadlock_watchdog;

    logic       clk;
    logic       rst;
    logic [1:0] axis;
    logic [2:0] idle;
    logic [2:0] blk;
    logic       clr;

    logic       kb_a, pl_a, fc_a;
    logic [1:0] cause_a;
    logic [15:0] cnt_a;
    logic       kb_b, pl_b, fc_b;
    logic [1:0] cause_b;
    logic [15:0] cnt_b;

    int n_chk = 0;
    int n_err = 0;

    axis_deadlock_watchdog #(.N_AXIS(2), .N_INST(3), .CNT_W(16), .THRESHOLD(8)) dut_a (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst),
        .axis_block_sigs      (axis),
        .inst_idle_sigs       (idle),
        .inst_block_sigs      (blk),
        .clear                (clr),
        .kernel_block         (kb_a),
        .deadlock_pulse       (pl_a),
        .block_cause          (cause_a),
        .first_chan           (fc_a),
        .stall_cnt            (cnt_a)
    );

    axis_deadlock_watchdog #(.N_AXIS(2), .N_INST(3), .CNT_W(16), .THRESHOLD(1)) dut_b (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst),
        .axis_block_sigs      (axis),
        .inst_idle_sigs       (idle),
        .inst_block_sigs      (blk),
        .clear                (clr),
        .kernel_block         (kb_b),
        .deadlock_pulse       (pl_b),
        .block_cause          (cause_b),
        .first_chan           (fc_b),
        .stall_cnt            (cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge, sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic stall_a();
        idle = 3'b001; blk = 3'b110; axis = 2'b10;
    endtask

    task automatic run_probes();
        idle = 3'b001; blk = 3'b000; axis = 2'b00;
    endtask

    int maxcnt;
    int kbseen;

    initial begin
        rst = 1'b1; clr = 1'b0;
        axis = '0; idle = '0; blk = '0;
        step();
        chk("rst_kb",    kb_a,    0);
        chk("rst_pulse", pl_a,    0);
        chk("rst_cause", cause_a, 0);
        chk("rst_fc",    fc_a,    0);
        chk("rst_cnt",   cnt_a,   0);
        rst = 1'b0;

        // a busy instance means progress even with a blocked stream
        idle = 3'b001; blk = 3'b000; axis = 2'b10;
        step(); step();
        chk("busy_inst_cnt", cnt_a, 0);

        // basic deadlock at THRESHOLD=8
        stall_a();
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t1_cnt%0d", k), cnt_a, k);
            chk($sformatf("t1_kb%0d", k),  kb_a,  0);
        end
        step();
        chk("t1_kb",    kb_a,    1);
        chk("t1_pulse", pl_a,    1);
        chk("t1_cause", cause_a, 2'b10);
        chk("t1_fc",    fc_a,    1);
        chk("t1_cnt",   cnt_a,   8);
        run_probes();
        step();
        chk("t1_pulse_off", pl_a,  0);
        chk("t1_sticky",    kb_a,  1);
        chk("t1_cnt_hold",  cnt_a, 8);
        chk("t1_cause_hold", cause_a, 2'b10);

        // clear with probes still stalled, then re-declare
        stall_a();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_kb",    kb_a,    0);
        chk("clr_cnt",   cnt_a,   0);
        chk("clr_cause", cause_a, 0);
        chk("clr_fc",    fc_a,    0);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("re_cnt%0d", k), cnt_a, k);
        end
        chk("re_kb_pre", kb_a, 0);
        step();
        chk("re_kb",    kb_a, 1);
        chk("re_pulse", pl_a, 1);

        // one progressing cycle at count 5 restarts the count
        do_reset();
        stall_a();
        for (int k = 1; k <= 5; k++) step();
        chk("t2_cnt5", cnt_a, 5);
        run_probes();
        step();
        chk("t2_cnt0", cnt_a, 0);
        stall_a();
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t2_cnt%0d", k), cnt_a, k);
        end
        chk("t2_kb_pre", kb_a, 0);
        step();
        chk("t2_kb", kb_a, 1);

        // all-idle kernel never stalls
        do_reset();
        idle = 3'b111; blk = 3'b000; axis = 2'b11;
        maxcnt = 0; kbseen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (int'(cnt_a) > maxcnt) maxcnt = int'(cnt_a);
            if (kb_a) kbseen = 1;
        end
        chk("idle_cnt_max", maxcnt, 0);
        chk("idle_kb",      kbseen, 0);

        // asynchronous reset mid-count
        do_reset();
        stall_a();
        for (int k = 1; k <= 6; k++) step();
        chk("t5_cnt6", cnt_a, 6);
        #2 rst = 1'b1;
        #1;
        chk("t5_cnt",   cnt_a,   0);
        chk("t5_kb",    kb_a,    0);
        chk("t5_pulse", pl_a,    0);
        chk("t5_cause", cause_a, 0);
        chk("t5_fc",    fc_a,    0);
        step();
        rst = 1'b0;
        step();
        chk("t5_run", cnt_a, 1);

        // THRESHOLD=1, instance-internal block only
        do_reset();
        idle = 3'b101; blk = 3'b010; axis = 2'b00;
        chk("t6_kb_pre", kb_b, 0);
        step();
        chk("t6_kb",    kb_b,    1);
        chk("t6_pulse", pl_b,    1);
        chk("t6_cause", cause_b, 0);
        chk("t6_fc",    fc_b,    0);
        chk("t6_cnt",   cnt_b,   1);
        step();
        chk("t6_pulse_off", pl_b, 0);

        // both ports blocked: lowest index wins
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_clr_kb", kb_b, 0);
        axis = 2'b11;
        step();
        chk("t6b_kb",    kb_b,    1);
        chk("t6b_cause", cause_b, 2'b11);
        chk("t6b_fc",    fc_b,    0);

        // port 1 only on the THRESHOLD=1 instance
        clr = 1'b1;
        step();
        clr = 1'b0;
        axis = 2'b10;
        step();
        chk("t6c_fc", fc_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
